// File: rtl/core_branch_resolve.sv
// core_branch_resolve
// Execute-stage branch resolution for the RV32I pipeline. It evaluates the
// B-type condition, computes the branch target and flags a mispredict when
// the outcome differs from the prediction that fetch used. It also owns the
// branch history table (2-bit saturating counters) that fetch reads through
// the lookup port.
//
// Ports
//   CLK, RST                 clock (rising edge), synchronous active-high reset
//   C_BRANCH                 resolve request, one branch per cycle
//   FUNCT3                   branch kind (BEQ/BNE/BLT/BGE/BLTU/BGEU)
//   REG_RDATA1, REG_RDATA2   rs1 / rs2 operand values
//   BR_PC, BR_IMM            branch PC and sign-extended B-immediate
//   PRED_TAKEN_IN            prediction fetch used for this branch
//   LOOKUP_PC / LOOKUP_PRED  BHT lookup request / registered prediction
//   RESOLVE_VALID            one-cycle pulse marking a fresh result
//   TAKE_BRANCH              condition met
//   BRANCH_TARGET            BR_PC + BR_IMM (modulo 2^XLEN)
//   MISPREDICT               outcome differs from PRED_TAKEN_IN
//   ILLEGAL                  FUNCT3 is not a branch encoding
//   MISALIGN                 taken with a target that is not word aligned
//   CLR_PERF / MISPRED_CNT   clear / saturating mispredict counter
module core_branch_resolve #(
    parameter int XLEN      = 32,
    parameter int BHT_DEPTH = 64,
    parameter int PERF_W    = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              C_BRANCH,
    input  logic [2:0]        FUNCT3,
    input  logic [XLEN-1:0]   REG_RDATA1,
    input  logic [XLEN-1:0]   REG_RDATA2,
    input  logic [XLEN-1:0]   BR_PC,
    input  logic [XLEN-1:0]   BR_IMM,
    input  logic              PRED_TAKEN_IN,
    input  logic [XLEN-1:0]   LOOKUP_PC,
    output logic              LOOKUP_PRED,
    output logic              RESOLVE_VALID,
    output logic              TAKE_BRANCH,
    output logic [XLEN-1:0]   BRANCH_TARGET,
    output logic              MISPREDICT,
    output logic              ILLEGAL,
    output logic              MISALIGN,
    input  logic              CLR_PERF,
    output logic [PERF_W-1:0] MISPRED_CNT
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    logic [1:0]        bht_r [BHT_DEPTH];
    logic              lookup_pred_r;
    logic              resolve_valid_r;
    logic              take_branch_r;
    logic [XLEN-1:0]   branch_target_r;
    logic              mispredict_r;
    logic              illegal_r;
    logic              misalign_r;
    logic [PERF_W-1:0] mispred_cnt_r;

    logic              legal_s;
    logic              cond_s;
    logic [XLEN-1:0]   target_s;
    logic [IDX_W-1:0]  upd_idx_s;
    logic [IDX_W-1:0]  look_idx_s;
    logic [1:0]        cur_ctr_s;
    logic [1:0]        new_ctr_s;
    logic              do_upd_s;
    logic              mispred_s;
    logic              lookup_next_s;

    // PC bits [1:0] are always zero for aligned code, so the index starts at bit 2.
    assign upd_idx_s  = BR_PC[IDX_W+1:2];
    assign look_idx_s = LOOKUP_PC[IDX_W+1:2];
    assign target_s   = BR_PC + BR_IMM;

    // Branch condition decode; funct3 010/011 are not branches.
    always_comb begin
        cond_s  = 1'b0;
        legal_s = 1'b1;
        case (FUNCT3)
            3'b000:  cond_s = (REG_RDATA1 == REG_RDATA2);
            3'b001:  cond_s = (REG_RDATA1 != REG_RDATA2);
            3'b100:  cond_s = ($signed(REG_RDATA1) <  $signed(REG_RDATA2));
            3'b101:  cond_s = ($signed(REG_RDATA1) >= $signed(REG_RDATA2));
            3'b110:  cond_s = (REG_RDATA1 <  REG_RDATA2);
            3'b111:  cond_s = (REG_RDATA1 >= REG_RDATA2);
            default: legal_s = 1'b0;
        endcase
    end

    assign do_upd_s  = C_BRANCH & legal_s;
    assign mispred_s = do_upd_s & (cond_s != PRED_TAKEN_IN);
    assign cur_ctr_s = bht_r[upd_idx_s];

    // Saturating counter step toward the resolved outcome.
    always_comb begin
        new_ctr_s = cur_ctr_s;
        if (cond_s) begin
            if (cur_ctr_s != 2'd3) begin
                new_ctr_s = cur_ctr_s + 2'd1;
            end else begin
                new_ctr_s = 2'd3;
            end
        end else begin
            if (cur_ctr_s != 2'd0) begin
                new_ctr_s = cur_ctr_s - 2'd1;
            end else begin
                new_ctr_s = 2'd0;
            end
        end
    end

    // Lookup with write-first bypass so fetch never sees a stale counter.
    always_comb begin
        lookup_next_s = 1'b0;
        if (do_upd_s && (look_idx_s == upd_idx_s)) begin
            lookup_next_s = new_ctr_s[1];
        end else begin
            lookup_next_s = bht_r[look_idx_s][1];
        end
    end

    // Result registers, BHT state and mispredict counter.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht_r[i] <= 2'b01;
            end
            lookup_pred_r   <= 1'b0;
            resolve_valid_r <= 1'b0;
            take_branch_r   <= 1'b0;
            branch_target_r <= '0;
            mispredict_r    <= 1'b0;
            illegal_r       <= 1'b0;
            misalign_r      <= 1'b0;
            mispred_cnt_r   <= '0;
        end else begin
            lookup_pred_r   <= lookup_next_s;
            resolve_valid_r <= C_BRANCH;
            if (C_BRANCH) begin
                take_branch_r   <= legal_s & cond_s;
                branch_target_r <= target_s;
                mispredict_r    <= mispred_s;
                illegal_r       <= ~legal_s;
                misalign_r      <= legal_s & cond_s & (target_s[1:0] != 2'b00);
            end else begin
                // Take/target hold their last value; flags clear.
                mispredict_r <= 1'b0;
                illegal_r    <= 1'b0;
                misalign_r   <= 1'b0;
            end
            if (do_upd_s) begin
                bht_r[upd_idx_s] <= new_ctr_s;
            end
            if (CLR_PERF) begin
                mispred_cnt_r <= '0;
            end else if (mispred_s && (mispred_cnt_r != {PERF_W{1'b1}})) begin
                mispred_cnt_r <= mispred_cnt_r + {{(PERF_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign LOOKUP_PRED   = lookup_pred_r;
    assign RESOLVE_VALID = resolve_valid_r;
    assign TAKE_BRANCH   = take_branch_r;
    assign BRANCH_TARGET = branch_target_r;
    assign MISPREDICT    = mispredict_r;
    assign ILLEGAL       = illegal_r;
    assign MISALIGN      = misalign_r;
    assign MISPRED_CNT   = mispred_cnt_r;

endmodule
